// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: memory op codes,
// arbiter state encoding and response port-select constants.
package mem_arbiter_pkg;

    // Memory op codes: bit 2 clear = store, bit 2 set = load
    localparam logic [2:0] OP_STORE_BYTE = 3'b000;
    localparam logic [2:0] OP_STORE_HALF = 3'b001;
    localparam logic [2:0] OP_STORE_WORD = 3'b010;
    localparam logic [2:0] OP_LOAD_BYTE  = 3'b100;
    localparam logic [2:0] OP_LOAD_HALF  = 3'b101;
    localparam logic [2:0] OP_LOAD_WORD  = 3'b110;

    // Arbiter ownership state
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_C_OWN  = 2'd1,
        ST_D_OWN  = 2'd2,
        ST_D_LOCK = 2'd3
    } arb_state_e;

    // Response routing select
    localparam logic SEL_C = 1'b0;
    localparam logic SEL_D = 1'b1;

    function automatic logic op_is_load(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/mem_arb_wait_cnt.sv
// Saturating count of consecutive cycles port D has been refused.
// Saturation flag lets D take priority for one grant.
module mem_arb_wait_cnt
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          clr_i,
    input  logic                          inc_i,
    output logic [$clog2(MAX_WAIT+1)-1:0] cnt_o,
    output logic                          sat_o
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign sat_o = (cnt_q == CW'(MAX_WAIT));
    assign cnt_o = cnt_q;

    // Next count: clear wins, otherwise increment until saturated
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the single-port data memory (core port C, DMA/loader
// port D). One grant per cycle, combinational; load data routed back to the
// winner one cycle later. Optional macro MEM_ARB_LOCK_EN adds the d_lock_i
// port and the D_LOCK state for uninterrupted D bursts.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int AW       = 11
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          c_req_i,
    input  logic [2:0]    c_op_i,
    input  logic [AW-1:0] c_addr_i,
    input  logic [31:0]   c_wdata_i,
    output logic          c_gnt_o,
    output logic          c_rvalid_o,
    output logic [31:0]   c_rdata_o,
    input  logic          d_req_i,
    input  logic [2:0]    d_op_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [31:0]   d_wdata_i,
    output logic          d_gnt_o,
    output logic          d_rvalid_o,
    output logic [31:0]   d_rdata_o,
`ifdef MEM_ARB_LOCK_EN
    input  logic          d_lock_i,
`endif
    output logic          m_stall_o,
    output logic [2:0]    m_op_o,
    output logic [AW-1:0] m_addr_o,
    output logic [31:0]   m_wdata_o,
    input  logic [31:0]   m_rdata_i
);
    arb_state_e    state_q, state_d;
    logic          wait_sat;
    logic          lock_hold;
    logic          rvalid_q, rvalid_d;
    logic          rsp_sel_q, rsp_sel_d;
    logic [2:0]    last_op_q;
    logic [AW-1:0] last_addr_q;

    mem_arb_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_wait (
        .clk   (clk),
        .nrst  (nrst),
        .clr_i (d_gnt_o | ~d_req_i),
        .inc_i (d_req_i & ~d_gnt_o),
        .cnt_o (),
        .sat_o (wait_sat)
    );

`ifdef MEM_ARB_LOCK_EN
    assign lock_hold = (state_q == ST_D_LOCK);
`else
    assign lock_hold = 1'b0;
`endif

    // Grant: D on no contention, on starvation guard or while locked; else C
    always_comb begin
        d_gnt_o = d_req_i & (~c_req_i | wait_sat | lock_hold);
        c_gnt_o = c_req_i & ~d_gnt_o;
    end

    // Request mux onto memory bus; op/addr hold last driven values when idle
    always_comb begin
        m_op_o    = last_op_q;
        m_addr_o  = last_addr_q;
        m_wdata_o = c_wdata_i;
        m_stall_o = ~(c_gnt_o | d_gnt_o);
        if (d_gnt_o) begin
            m_op_o    = d_op_i;
            m_addr_o  = d_addr_i;
            m_wdata_o = d_wdata_i;
        end else if (c_gnt_o) begin
            m_op_o    = c_op_i;
            m_addr_o  = c_addr_i;
        end
    end

    // Capture the driven op/addr so they stay stable through idle cycles
    always_ff @(posedge clk) begin
        if (!m_stall_o) begin
            last_op_q   <= m_op_o;
            last_addr_q <= m_addr_o;
        end
    end

    // Ownership FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (d_gnt_o)      state_d = ST_D_OWN;
                else if (c_gnt_o) state_d = ST_C_OWN;
            end
            ST_C_OWN: begin
                if (d_gnt_o)       state_d = ST_D_OWN;
                else if (!c_gnt_o) state_d = ST_IDLE;
            end
            ST_D_OWN: begin
`ifdef MEM_ARB_LOCK_EN
                if (d_gnt_o && d_lock_i) state_d = ST_D_LOCK;
                else if (d_gnt_o)        state_d = ST_D_OWN;
`else
                if (d_gnt_o)             state_d = ST_D_OWN;
`endif
                else if (c_gnt_o)        state_d = ST_C_OWN;
                else                     state_d = ST_IDLE;
            end
            ST_D_LOCK: begin
`ifdef MEM_ARB_LOCK_EN
                if (!d_req_i || !d_lock_i) state_d = ST_IDLE;
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Response tracking: a load grant marks next cycle valid for its port
    always_comb begin
        rvalid_d  = (c_gnt_o & op_is_load(c_op_i)) | (d_gnt_o & op_is_load(d_op_i));
        rsp_sel_d = rsp_sel_q;
        if (rvalid_d) begin
            rsp_sel_d = d_gnt_o ? SEL_D : SEL_C;
        end
    end

    // Control registers: FSM state and response select/valid
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= ST_IDLE;
            rvalid_q  <= 1'b0;
            rsp_sel_q <= SEL_C;
        end else begin
            state_q   <= state_d;
            rvalid_q  <= rvalid_d;
            rsp_sel_q <= rsp_sel_d;
        end
    end

    // Route returning read data to the owning port, zero to the other
    always_comb begin
        c_rvalid_o = rvalid_q & (rsp_sel_q == SEL_C);
        d_rvalid_o = rvalid_q & (rsp_sel_q == SEL_D);
        c_rdata_o  = c_rvalid_o ? m_rdata_i : 32'h0;
        d_rdata_o  = d_rvalid_o ? m_rdata_i : 32'h0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a small byte-memory model on the
// memory side. Stimulus checks grants directly and queues expected load
// responses; a monitor pops and compares whenever an rvalid appears.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          nrst;
    logic          c_req, d_req;
    logic [2:0]    c_op, d_op;
    logic [AW-1:0] c_addr, d_addr;
    logic [31:0]   c_wdata, d_wdata;
    logic          c_gnt, d_gnt, c_rvalid, d_rvalid;
    logic [31:0]   c_rdata, d_rdata;
`ifdef MEM_ARB_LOCK_EN
    logic          d_lock;
`endif
    logic          m_stall;
    logic [2:0]    m_op;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [31:0]   m_rdata;

    mem_arbiter #(.MAX_WAIT(4), .AW(AW)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .c_req_i    (c_req),
        .c_op_i     (c_op),
        .c_addr_i   (c_addr),
        .c_wdata_i  (c_wdata),
        .c_gnt_o    (c_gnt),
        .c_rvalid_o (c_rvalid),
        .c_rdata_o  (c_rdata),
        .d_req_i    (d_req),
        .d_op_i     (d_op),
        .d_addr_i   (d_addr),
        .d_wdata_i  (d_wdata),
        .d_gnt_o    (d_gnt),
        .d_rvalid_o (d_rvalid),
        .d_rdata_o  (d_rdata),
`ifdef MEM_ARB_LOCK_EN
        .d_lock_i   (d_lock),
`endif
        .m_stall_o  (m_stall),
        .m_op_o     (m_op),
        .m_addr_o   (m_addr),
        .m_wdata_o  (m_wdata),
        .m_rdata_i  (m_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: little-endian bytes, sign-extending loads, 1-cycle read
    logic [7:0] mem [0:2047];
    always @(posedge clk) begin
        if (!m_stall) begin
            case (m_op)
                OP_LOAD_BYTE:  m_rdata <= {{24{mem[m_addr][7]}}, mem[m_addr]};
                OP_LOAD_HALF:  m_rdata <= {{16{mem[m_addr+1][7]}}, mem[m_addr+1], mem[m_addr]};
                OP_LOAD_WORD:  m_rdata <= {mem[m_addr+3], mem[m_addr+2], mem[m_addr+1], mem[m_addr]};
                OP_STORE_BYTE: mem[m_addr] <= m_wdata[7:0];
                OP_STORE_HALF: begin
                    mem[m_addr]   <= m_wdata[7:0];
                    mem[m_addr+1] <= m_wdata[15:8];
                end
                OP_STORE_WORD: begin
                    mem[m_addr]   <= m_wdata[7:0];
                    mem[m_addr+1] <= m_wdata[15:8];
                    mem[m_addr+2] <= m_wdata[23:16];
                    mem[m_addr+3] <= m_wdata[31:24];
                end
                default: ;
            endcase
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        port;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    task automatic push_rsp(input logic port, input logic [31:0] data);
        exp_t e;
        e.port = port;
        e.data = data;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
    endtask

    // Monitor: every rvalid must match the oldest queued expectation
    always @(negedge clk) begin
        if (nrst && (c_rvalid || d_rvalid)) begin
            exp_t e;
            chk("rsp_both_valid", {31'b0, c_rvalid & d_rvalid}, 32'h0);
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'h1, 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_port", {31'b0, d_rvalid}, {31'b0, e.port});
                chk("rsp_data", d_rvalid ? d_rdata : c_rdata, e.data);
                chk("rsp_other_zero", d_rvalid ? c_rdata : d_rdata, 32'h0);
                chk("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic clear_reqs;
        c_req = 1'b0; d_req = 1'b0;
`ifdef MEM_ARB_LOCK_EN
        d_lock = 1'b0;
`endif
    endtask

    task automatic exp_gnt(input string name, input logic cg, input logic dg);
        chk({name, "_c_gnt"},   {31'b0, c_gnt},   {31'b0, cg});
        chk({name, "_d_gnt"},   {31'b0, d_gnt},   {31'b0, dg});
        chk({name, "_m_stall"}, {31'b0, m_stall}, {31'b0, ~(cg | dg)});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        {mem[16'h013], mem[16'h012], mem[16'h011], mem[16'h010]} = 32'h11223344;
        {mem[16'h007], mem[16'h006], mem[16'h005], mem[16'h004]} = 32'hCAFEF00D;
        {mem[16'h407], mem[16'h406], mem[16'h405], mem[16'h404]} = 32'h0BADBEEF;
        m_rdata = 32'h0;
        nrst = 1'b0;
        clear_reqs();
        c_op = OP_LOAD_WORD; d_op = OP_LOAD_WORD;
        c_addr = '0; d_addr = '0; c_wdata = '0; d_wdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_c_rvalid", {31'b0, c_rvalid}, 32'h0);
        chk("rst_d_rvalid", {31'b0, d_rvalid}, 32'h0);
        chk("rst_m_stall",  {31'b0, m_stall},  32'h1);
        nrst = 1'b1;

        // 1: C-only load word
        @(negedge clk);
        c_req = 1'b1; c_op = OP_LOAD_WORD; c_addr = 11'h010;
        #1 exp_gnt("t1", 1'b1, 1'b0);
        chk("t1_m_addr", 32'(m_addr), 32'h010);
        chk("t1_m_op",   32'(m_op),   32'(OP_LOAD_WORD));
        push_rsp(SEL_C, 32'h11223344);
        @(negedge clk); clear_reqs();

        // 2: contention, both storing; D wins once after 4 refusals
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            c_req = 1'b1; c_op = OP_STORE_WORD; c_addr = 11'h020; c_wdata = 32'h0000C0DE;
            d_req = 1'b1; d_op = OP_STORE_WORD; d_addr = 11'h420; d_wdata = 32'h0000D00D;
            #1 exp_gnt($sformatf("t2_cyc%0d", i), i != 4, i == 4);
            if (i == 4) chk("t2_m_addr_d", 32'(m_addr), 32'h420);
        end
        @(negedge clk); clear_reqs();

        // 3: alternating loads C then D, back-to-back
        @(negedge clk);
        c_req = 1'b1; c_op = OP_LOAD_WORD; c_addr = 11'h004;
        #1 exp_gnt("t3a", 1'b1, 1'b0);
        chk("t3a_bank", {31'b0, m_addr[10]}, 32'h0);
        push_rsp(SEL_C, 32'hCAFEF00D);
        @(negedge clk);
        c_req = 1'b0;
        d_req = 1'b1; d_op = OP_LOAD_WORD; d_addr = 11'h404;
        #1 exp_gnt("t3b", 1'b0, 1'b1);
        chk("t3b_bank", {31'b0, m_addr[10]}, 32'h1);
        push_rsp(SEL_D, 32'h0BADBEEF);
        @(negedge clk); clear_reqs();
        #1 exp_gnt("t3_idle", 1'b0, 1'b0);
        chk("t3_hold_addr", 32'(m_addr), 32'h404);
        chk("t3_hold_op",   32'(m_op),   32'(OP_LOAD_WORD));

        // 4: D store byte, then C load byte of the same location
        @(negedge clk);
        d_req = 1'b1; d_op = OP_STORE_BYTE; d_addr = 11'h003; d_wdata = 32'h000000A5;
        #1 exp_gnt("t4_st", 1'b0, 1'b1);
        chk("t4_m_op",    32'(m_op), 32'(OP_STORE_BYTE));
        chk("t4_m_wdata", m_wdata,   32'h000000A5);
        @(negedge clk);
        d_req = 1'b0;
        c_req = 1'b1; c_op = OP_LOAD_BYTE; c_addr = 11'h003;
        #1 exp_gnt("t4_ld", 1'b1, 1'b0);
        push_rsp(SEL_C, 32'hFFFFFFA5);
        @(negedge clk); clear_reqs();
        @(negedge clk);

        // 5: reset in the cycle after a C load grant drops the response
        @(negedge clk);
        c_req = 1'b1; c_op = OP_LOAD_WORD; c_addr = 11'h010;
        d_req = 1'b1; d_op = OP_STORE_WORD; d_addr = 11'h500;
        #1 exp_gnt("t5", 1'b1, 1'b0);
        @(posedge clk);
        #1 nrst = 1'b0; clear_reqs();
        #1;
        chk("t5_c_rvalid", {31'b0, c_rvalid}, 32'h0);
        chk("t5_m_stall",  {31'b0, m_stall},  32'h1);
        chk("t5_wait_cnt", 32'(dut.u_wait.cnt_q), 32'h0);
        chk("t5_state",    32'(dut.state_q), 32'(ST_IDLE));
        @(negedge clk); nrst = 1'b1;
        repeat (2) @(negedge clk);

`ifdef MEM_ARB_LOCK_EN
        // 6: locked D burst holds off C
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            d_req = 1'b1; d_lock = 1'b1; d_op = OP_STORE_WORD; d_addr = 11'h600; d_wdata = 32'h1;
            #1 exp_gnt($sformatf("t6_pre%0d", i), 1'b0, 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            c_req = 1'b1; c_op = OP_STORE_WORD; c_addr = 11'h040; c_wdata = 32'h2;
            #1 exp_gnt($sformatf("t6_lock%0d", i), 1'b0, 1'b1);
        end
        @(negedge clk);
        d_req = 1'b0; d_lock = 1'b0;
        #1 exp_gnt("t6_release", 1'b1, 1'b0);
        @(negedge clk); clear_reqs();
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
